// File: rtl/s_bus_arbiter.sv
// Round-robin arbiter that drives the one-hot enables of the six OR-combined S-bus sources.
// Optional macro S_BUS_ARB_PRIO0_EN gives source 0 fixed top priority at each arbitration point.
module s_bus_arbiter #(
    parameter int NUM_SRC  = 6,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] last,
    output logic [NUM_SRC-1:0] grant,
    output logic               grant_valid,
    output logic [2:0]         grant_id,
    output logic [3:0]         hold_cnt
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_SRC-1:0] r_grant, w_grant_nxt;
    logic [2:0]         r_gid, w_gid_nxt;
    logic [2:0]         r_ptr, w_ptr_nxt;
    logic [3:0]         r_hold, w_hold_nxt;
    logic               r_valid, w_valid_nxt;

    logic               w_g_req, w_g_last, w_release;
    logic [NUM_SRC-1:0] w_others;
    logic [2:0]         w_rel_ptr;
    logic [2:0]         w_pick;

    // First set bit of rq searching from ptr upward, wrapping modulo 6.
    function automatic logic [2:0] pick(input logic [2:0] ptr, input logic [NUM_SRC-1:0] rq);
        int         s;
        logic [2:0] idx;
        pick = ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= NUM_SRC) s = s - NUM_SRC;
            idx = 3'(s);
            if (rq[idx]) pick = idx;
        end
`ifdef S_BUS_ARB_PRIO0_EN
        if (rq[0]) pick = 3'd0;
`endif
    endfunction

    assign w_g_req   = req[r_gid];
    assign w_g_last  = last[r_gid];
    assign w_release = !w_g_req || w_g_last || (r_hold == 4'(MAX_HOLD));
    // The grantee is masked out so it can never win its own re-arbitration.
    assign w_others  = req & ~r_grant;
    assign w_rel_ptr = (r_gid == 3'(NUM_SRC - 1)) ? 3'd0 : r_gid + 3'd1;
    assign w_pick    = (r_state == S_IDLE) ? pick(r_ptr, req) : pick(w_rel_ptr, w_others);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gid_nxt   = r_gid;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_valid_nxt = r_valid;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_GRANT;
                    w_gid_nxt   = w_pick;
                    w_grant_nxt = NUM_SRC'(1) << w_pick;
                    w_hold_nxt  = 4'd1;
                    w_valid_nxt = 1'b1;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_ptr_nxt = w_rel_ptr;
                    if (|w_others) begin
                        w_gid_nxt   = w_pick;
                        w_grant_nxt = NUM_SRC'(1) << w_pick;
                        w_hold_nxt  = 4'd1;
                    end else if (w_g_req && !w_g_last) begin
                        // Sole requester cut off by the hold limit: fresh tenure.
                        w_hold_nxt = 4'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = '0;
                        w_gid_nxt   = 3'd0;
                        w_hold_nxt  = 4'd0;
                        w_valid_nxt = 1'b0;
                    end
                end else begin
                    w_hold_nxt = r_hold + 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_gid   <= 3'd0;
            r_ptr   <= 3'd0;
            r_hold  <= 4'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gid   <= w_gid_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_id    = r_gid;
    assign hold_cnt    = r_hold;

endmodule

// File: tb/tb_s_bus_arbiter.sv
// Bench for s_bus_arbiter: vector table plus hand sequences, expected grants queued per step.
module tb_s_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] req = '0;
    logic [5:0] last = '0;
    logic [5:0] grant;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic [3:0] hold_cnt;

    s_bus_arbiter #(.NUM_SRC(6), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last),
        .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit         rst;
        logic [5:0] req;
        logic [5:0] last;
        logic [5:0] g;
        logic [3:0] h;
    } vec_t;

    typedef struct {
        logic [5:0] g;
        logic [3:0] h;
        int         tag;
    } exp_t;

    vec_t tv[$];
    exp_t sbq[$];

    function automatic logic [2:0] enc(input logic [5:0] oh);
        enc = 3'd0;
        for (int i = 0; i < 6; i++) if (oh[i]) enc = 3'(i);
    endfunction

    task automatic check(input string nm, input int tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        #1;
        check("rst_grant", -1, 8'(grant), 8'h00);
        check("rst_valid", -1, 8'(grant_valid), 8'h00);
        check("rst_id", -1, 8'(grant_id), 8'h00);
        check("rst_hold", -1, 8'(hold_cnt), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [5:0] rq, input logic [5:0] lt,
                        input logic [5:0] eg, input logic [3:0] eh, input int tag);
        exp_t e;
        req  = rq;
        last = lt;
        sbq.push_back('{eg, eh, tag});
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard step %0d: queue empty", tag);
        end else begin
            e = sbq.pop_front();
            check("grant", e.tag, 8'(grant), 8'(e.g));
            check("grant_id", e.tag, 8'(grant_id), 8'(enc(e.g)));
            check("grant_valid", e.tag, 8'(grant_valid), 8'(|e.g));
            check("onehot0", e.tag, 8'($onehot0(grant)), 8'h01);
            if (e.g != 6'b0) check("hold_cnt", e.tag, 8'(hold_cnt), 8'(e.h));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] exp_g;

        // Single requester: hold limit, back-to-back re-grant, drop.
        tv.push_back('{1'b1, 6'b000001, 6'b000000, 6'b000001, 4'd1});
        tv.push_back('{1'b0, 6'b000001, 6'b000000, 6'b000001, 4'd2});
        tv.push_back('{1'b0, 6'b000001, 6'b000000, 6'b000001, 4'd3});
        tv.push_back('{1'b0, 6'b000001, 6'b000000, 6'b000001, 4'd4});
        tv.push_back('{1'b0, 6'b000001, 6'b000000, 6'b000001, 4'd1});
        tv.push_back('{1'b0, 6'b000001, 6'b000000, 6'b000001, 4'd2});
        tv.push_back('{1'b0, 6'b000000, 6'b000000, 6'b000000, 4'd0});
        // Two requesters, each ending with last in its first cycle.
        tv.push_back('{1'b1, 6'b100100, 6'b000000, 6'b000100, 4'd1});
        tv.push_back('{1'b0, 6'b100100, 6'b000100, 6'b100000, 4'd1});
        tv.push_back('{1'b0, 6'b100100, 6'b100000, 6'b000100, 4'd1});
        tv.push_back('{1'b0, 6'b100100, 6'b000000, 6'b000100, 4'd2});
        tv.push_back('{1'b0, 6'b000000, 6'b000000, 6'b000000, 4'd0});
        // Grantee 3 drops its request while 5 waits; no preemption before that.
        tv.push_back('{1'b1, 6'b001000, 6'b000000, 6'b001000, 4'd1});
        tv.push_back('{1'b0, 6'b101000, 6'b000000, 6'b001000, 4'd2});
        tv.push_back('{1'b0, 6'b100000, 6'b000000, 6'b100000, 4'd1});
        tv.push_back('{1'b0, 6'b000000, 6'b000000, 6'b000000, 4'd0});
        // last coinciding with the hold limit ends the tenure instead of re-granting.
        tv.push_back('{1'b1, 6'b000010, 6'b000000, 6'b000010, 4'd1});
        tv.push_back('{1'b0, 6'b000010, 6'b000000, 6'b000010, 4'd2});
        tv.push_back('{1'b0, 6'b000010, 6'b000000, 6'b000010, 4'd3});
        tv.push_back('{1'b0, 6'b000010, 6'b000000, 6'b000010, 4'd4});
        tv.push_back('{1'b0, 6'b000010, 6'b000010, 6'b000000, 4'd0});

        #2;
        foreach (tv[i]) begin
            if (tv[i].rst) do_reset();
            step(tv[i].req, tv[i].last, tv[i].g, tv[i].h, i);
        end

        // All six requesting: rotation 0..5,0 with four cycles each.
        do_reset();
        for (int k = 0; k < 25; k++)
            step(6'b111111, 6'b000000, 6'(6'b000001 << ((k / 4) % 6)), 4'((k % 4) + 1), 100 + k);
        step(6'b000000, 6'b000000, 6'b000000, 4'd0, 125);

        // Asynchronous reset in the middle of source 2's tenure.
        do_reset();
        step(6'b000100, 6'b000000, 6'b000100, 4'd1, 200);
        step(6'b000100, 6'b000000, 6'b000100, 4'd2, 201);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", 202, 8'(grant), 8'h00);
        check("async_rst_valid", 202, 8'(grant_valid), 8'h00);
        req = 6'b000000;
        @(negedge clk);
        rst_n = 1'b1;
        step(6'b000110, 6'b000000, 6'b000010, 4'd1, 203);
        step(6'b000000, 6'b000000, 6'b000000, 4'd0, 204);

        // Source 4 hits the hold limit while 0 waits; then ptr=2 with 0 and 3 requesting.
        do_reset();
        step(6'b010000, 6'b000000, 6'b010000, 4'd1, 300);
        step(6'b010001, 6'b000000, 6'b010000, 4'd2, 301);
        step(6'b010001, 6'b000000, 6'b010000, 4'd3, 302);
        step(6'b010001, 6'b000000, 6'b010000, 4'd4, 303);
        step(6'b010001, 6'b000000, 6'b000001, 4'd1, 304);
        step(6'b000000, 6'b000000, 6'b000000, 4'd0, 305);
        step(6'b000010, 6'b000000, 6'b000010, 4'd1, 306);
        step(6'b000000, 6'b000000, 6'b000000, 4'd0, 307);
`ifdef S_BUS_ARB_PRIO0_EN
        exp_g = 6'b000001;
`else
        exp_g = 6'b001000;
`endif
        step(6'b001001, 6'b000000, exp_g, 4'd1, 308);
        step(6'b000000, 6'b000000, 6'b000000, 4'd0, 309);

        if (sbq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
